// File: rtl/temp_avg_seq.sv
// -----------------------------------------------------------------------------
// temp_avg_seq
// Sequencer for the temperature-averaging path. On every one-second tick it
// requests one sensor sample and waits, with a timeout, for the sensor's ready
// handshake. It then pulses the accumulator enable. After N_SAMPLES
// accumulations it strobes the averager output register and clears the
// accumulator for the next window.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   i_enable       run request; low returns the sequencer to IDLE
//   i_sec          one-cycle tick, once per second
//   i_smp_ready    sensor sample valid (single-cycle or held)
//   o_smp_req      one-cycle sample request to the sensor
//   o_en_sum       accumulator add enable
//   o_rst_sum      accumulator clear
//   o_avg_load     one-cycle strobe; output register latches acc>>log2(N)
//   o_sample_idx   samples accumulated in the current window
//   o_err_timeout  sticky: sensor failed to answer within TIMEOUT_CYC
//   o_err_overrun  sticky: tick arrived while a sample was still in flight
// -----------------------------------------------------------------------------
module temp_avg_seq #(
  parameter int N_SAMPLES   = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CW          = $clog2(N_SAMPLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_enable,
  input  logic          i_sec,
  input  logic          i_smp_ready,
  output logic          o_smp_req,
  output logic          o_en_sum,
  output logic          o_rst_sum,
  output logic          o_avg_load,
  output logic [CW-1:0] o_sample_idx,
  output logic          o_err_timeout,
  output logic          o_err_overrun
);

  localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] IDX_LAST = CW'(N_SAMPLES - 1);

  // 3-bit encoding leaves one code unused; it decodes as IDLE.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SEC = 3'd1,
    S_REQ      = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_SUM      = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_sample_idx;
  logic          r_err_timeout;
  logic          r_err_overrun;
  logic          w_busy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_next_state = S_WAIT_SEC;
        else          w_next_state = S_IDLE;
      end
      S_WAIT_SEC: begin
        if (!i_enable)  w_next_state = S_IDLE;
        else if (i_sec) w_next_state = S_REQ;
        else            w_next_state = S_WAIT_SEC;
      end
      S_REQ: begin
        w_next_state = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        // A ready on the last allowed cycle still counts as an answer.
        if (i_smp_ready)               w_next_state = S_SUM;
        else if (r_timer == TMO_LAST)  w_next_state = S_ERR;
        else                           w_next_state = S_WAIT_RDY;
      end
      S_SUM: begin
        if (r_sample_idx == IDX_LAST) w_next_state = S_DONE;
        else                          w_next_state = S_WAIT_SEC;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      S_ERR: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // A sample is in flight from the request until the window bookkeeping ends.
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_REQ, S_WAIT_RDY, S_SUM, S_DONE, S_ERR: w_busy = 1'b1;
      default:                                 w_busy = 1'b0;
    endcase
  end

  // Timeout timer, sample index and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer       <= TW'(0);
      r_sample_idx  <= CW'(0);
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (i_sec && w_busy) begin
        r_err_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_sample_idx <= CW'(0);
        end
        S_WAIT_SEC: begin
          // Clear on the way out so IDLE already shows an empty window.
          if (!i_enable) r_sample_idx <= CW'(0);
        end
        S_REQ: begin
          r_timer <= TW'(0);
        end
        S_WAIT_RDY: begin
          if (!i_smp_ready && (r_timer != TMO_LAST)) r_timer <= r_timer + TW'(1);
        end
        S_SUM: begin
          if (r_sample_idx != IDX_LAST) r_sample_idx <= r_sample_idx + CW'(1);
        end
        S_DONE: begin
          r_sample_idx <= CW'(0);
        end
        S_ERR: begin
          r_err_timeout <= 1'b1;
          r_sample_idx  <= CW'(0);
        end
        default: begin
          r_sample_idx <= CW'(0);
        end
      endcase
    end
  end

  // Moore output decode; reset overrides it combinationally
  always_comb begin
    o_smp_req     = 1'b0;
    o_en_sum      = 1'b0;
    o_rst_sum     = 1'b0;
    o_avg_load    = 1'b0;
    o_sample_idx  = CW'(0);
    o_err_timeout = 1'b0;
    o_err_overrun = 1'b0;
    if (rst) begin
      o_rst_sum = 1'b1;
    end else begin
      o_sample_idx  = r_sample_idx;
      o_err_timeout = r_err_timeout;
      o_err_overrun = r_err_overrun;
      case (r_state)
        S_IDLE:     o_rst_sum  = 1'b1;
        S_WAIT_SEC: o_rst_sum  = 1'b0;
        S_REQ:      o_smp_req  = 1'b1;
        S_WAIT_RDY: o_smp_req  = 1'b0;
        S_SUM:      o_en_sum   = 1'b1;
        S_DONE:     o_avg_load = 1'b1;
        S_ERR:      o_rst_sum  = 1'b1;
        default:    o_rst_sum  = 1'b1;
      endcase
    end
  end

endmodule

// File: doc/temp_avg_seq.md
Name: temp_avg_seq

Overview:
Top-level sequencer for the temperature-averaging path. On each one-second tick it requests one sample from the sensor interface and waits for the sensor's ready handshake, with a timeout. It then pulses the accumulator enable. After N_SAMPLES accumulations it strobes the averager output register, clears the accumulator and starts the next window.

Parameters:
N_SAMPLES, 8, samples per averaging window; power of two, ≥2
TIMEOUT_CYC, 1000, maximum cycles spent in WAIT_RDY before an error is declared; ≥2
CW, $clog2(N_SAMPLES), width of the sample index (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run request; low returns the sequencer to IDLE
sec  in  1  one-cycle tick, once per second
smp_ready  in  1  sensor sample valid; single-cycle or held
smp_req  out  1  one-cycle sample request to the sensor
en_sum  out  1  accumulator add enable
rst_sum  out  1  accumulator clear
avg_load  out  1  one-cycle strobe; output register latches acc>>log2(N_SAMPLES)
sample_idx  out  CW  samples accumulated in the current window
err_timeout  out  1  sticky: sensor failed to answer within TIMEOUT_CYC
err_overrun  out  1  sticky: sec arrived while a sample was still in flight

Behaviour:
- Reset is synchronous and active-high on clk (rst).
- While rst=1: state←IDLE, sample_idx←0, timer←0, both error flags←0. Outputs forced combinationally to rst_sum=1 and all others 0.
- Moore machine. Outputs are decoded from the state register only. States and transitions:
  - IDLE: rst_sum=1. Next is WAIT_SEC if enable, else IDLE. sample_idx←0.
  - WAIT_SEC: all strobes 0. Next is IDLE if !enable. Else REQ if sec. Else stay.
  - REQ: smp_req=1 for exactly one cycle. timer←0. Next is WAIT_RDY.
  - WAIT_RDY: next is SUM if smp_ready. Else ERR if timer==TIMEOUT_CYC-1. Else timer++ and stay.
    - smp_ready in the same cycle as the timeout: SUM wins.
    - A smp_ready seen outside WAIT_RDY is ignored.
  - SUM: en_sum=1 for one cycle.
    - If sample_idx==N_SAMPLES-1: next is DONE.
    - Else sample_idx++ and next is WAIT_SEC.
  - DONE: avg_load=1 for one cycle. sample_idx←0. Next is IDLE, which clears the accumulator.
  - ERR: rst_sum=1. err_timeout←1. sample_idx←0. Next is IDLE. The partial window is discarded and no avg_load is issued.
- Latency: a sec seen in WAIT_SEC at cycle t gives smp_req at t+1. A smp_ready at cycle r gives en_sum at r+1. The last en_sum at cycle s gives avg_load at s+1 and rst_sum at s+2.
- sec in REQ, WAIT_RDY, SUM, DONE or ERR: err_overrun←1 and the tick is dropped (no queuing).
- sec in IDLE: ignored, no flag.
- enable deasserted mid-window: honoured only in WAIT_SEC. An in-flight sample completes its SUM, then the machine returns to WAIT_SEC, sees !enable and goes to IDLE. The accumulator is cleared and no avg_load is issued.
- Error flags are cleared only by rst.
- Undefined state encoding: next state is IDLE and outputs take their IDLE values.
- sample_idx wraps only via the explicit clear. It never exceeds N_SAMPLES-1.

Test Plan:
- Nominal window (N_SAMPLES=4, TIMEOUT_CYC=16):
  - Stimulus: enable=1; four sec pulses 20 cycles apart; smp_ready 2 cycles after each smp_req.
  - Required: exactly 4 en_sum pulses, each 1 cycle after its smp_ready. sample_idx steps 0→1→2→3. One avg_load 1 cycle after the 4th en_sum, then rst_sum the following cycle.
- Timeout:
  - Stimulus: sec, then smp_ready never asserted.
  - Required: ERR entered exactly 16 cycles after WAIT_RDY entry. err_timeout=1 and stays 1. No en_sum, no avg_load. The next sec restarts at sample_idx=0.
- Ready on the timeout boundary:
  - Stimulus: smp_ready in the 16th WAIT_RDY cycle.
  - Required: SUM taken, en_sum=1, err_timeout stays 0.
- Overrun:
  - Stimulus: second sec arrives 1 cycle after smp_req, while in WAIT_RDY.
  - Required: err_overrun=1. Only one smp_req issued. The window continues normally.
- Enable drop mid-window:
  - Stimulus: after 2 samples, enable=0 while in WAIT_SEC.
  - Required: next cycle IDLE with rst_sum=1 and sample_idx=0. No avg_load.
- Reset mid-operation:
  - Stimulus: rst=1 during WAIT_RDY with err_overrun set.
  - Required: same cycle rst_sum=1 and smp_req/en_sum/avg_load=0. After the clock edge: state IDLE, flags=0, sample_idx=0.
